instruction_decoder: RTL and testbench
======================================

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 MEMDATA  in  12  memory read data; valid in every cycle STB_FETCH is high.
REQ-004 STB_FETCH, STB_AUTOINC1, STB_AUTOINC2, STB_INDIRECT  in  1 each  sequencer phase strobes, one-cycle pulses.
REQ-005 STB_1..STB_6  in  1 each  sequencer execute-step strobes, one-cycle pulses.
REQ-006 SEQTYPE  out  2  {instIsPPIND, instIsIND}; selects the sequencer path after fetch.
REQ-007 DONE  out  1  one-cycle pulse; ends the current instruction.
REQ-008 IR  out  12  latched instruction word.
REQ-009 instAND, instTAD, instISZ, instDCA, instJMS, instJMP, instIOT, instOPR  out  1 each  one-hot opcode decode, gated by VALID.
REQ-010 VALID  out  1  IR holds a fetched instruction.
REQ-011 ERR  out  1  sticky step-overrun flag.

Function
REQ-012 On a STB_FETCH cycle, the block SHALL load IR <= MEMDATA and set VALID at the next edge.
REQ-013 Opcode SHALL be IR[11:9]: 0 AND, 1 TAD, 2 ISZ, 3 DCA, 4 JMS, 5 JMP, 6 IOT, 7 OPR.
REQ-014 instIsIND SHALL be bit 8 for opcodes 0-5 and 0 for opcodes 6-7.
REQ-015 instIsPPIND SHALL be instIsIND AND bit 7 = 0 AND bits 6:3 = 4'b0001 (addresses 0010-0017 octal).
REQ-016 SEQTYPE SHALL be combinational from MEMDATA while STB_FETCH is high, and from IR otherwise; value 2'b10 SHALL never be driven.
REQ-017 Execute step count N per opcode SHALL be: AND 1, TAD 1, ISZ 3, DCA 1, JMS 2, JMP 1, IOT 2, OPR 3.
REQ-018 A 3-bit step register SHALL clear on STB_FETCH and increment on each STB_1..STB_6 pulse.
REQ-019 DONE SHALL be registered and high for exactly the one cycle following the STB_n pulse with n = N.
REQ-020 STB_AUTOINC1/2 and STB_INDIRECT SHALL NOT change the step register or DONE.
REQ-021 An STB_n that does not equal the current step+1 SHALL be ignored.
REQ-022 If STB_6 arrives with N < 6 and DONE not yet issued, the block SHALL pulse DONE next cycle and set ERR.
REQ-023 STB_FETCH during an unfinished instruction SHALL abort it: relatch IR, clear the step register, suppress any pending DONE.
REQ-024 STB_FETCH and a final STB_n in the same cycle: fetch SHALL win and no DONE SHALL be issued.
REQ-025 After DONE, instruction decode outputs SHALL hold until the next STB_FETCH.

Reset
REQ-026 While RESET_N = 0: IR = 0, VALID = 0, all inst* = 0, DONE = 0, ERR = 0, step = 0, and SEQTYPE = 00 (STB_FETCH low).
REQ-027 Reset mid-instruction SHALL discard the instruction with no DONE; operation resumes at the next STB_FETCH.
REQ-028 ERR SHALL clear only on reset.

Configuration
REQ-029 With DECODER_IOT_EN defined: IOT SHALL use N = 2, and instIOT SHALL decode normally.
REQ-030 Without DECODER_IOT_EN: IOT SHALL use N = 1 and instIOT SHALL be tied 0; opcode 6 otherwise behaves as a NOP.

Verification
REQ-031 Fetch 1234 (TAD, direct), STB_1 -> SEQTYPE = 00 during fetch; DONE pulse one cycle after STB_1; instTAD = 1.
REQ-032 Fetch 0410 (AND I 0010) -> SEQTYPE = 11; AUTOINC/INDIRECT strobes leave DONE low; DONE one cycle after STB_1.
REQ-033 Fetch 2600 (ISZ I, page 1) -> SEQTYPE = 01; no DONE after STB_1 or STB_2; DONE after STB_3.
REQ-034 Fetch 7200 (OPR), STB_1..STB_2, then STB_FETCH 5000 -> no DONE; IR = 5000; instJMP = 1; DONE after next STB_1.
REQ-035 Fetch 3000 (DCA), suppress DONE response, drive STB_1..STB_6 -> single DONE after STB_1; ERR stays 0. Then force an overrun via out-of-order strobes ending at STB_6 -> DONE pulse; ERR = 1 until RESET_N low.
REQ-036 Fetch 6031: with DECODER_IOT_EN, DONE after STB_2 and instIOT = 1; without it, DONE after STB_1 and instIOT = 0.

Source files
------------

// File: rtl/instruction_decoder.sv
// Instruction decoder with execute-step tracking.
// It latches the fetched word into IR and decodes the opcode. It counts the
// sequencer execute strobes and pulses DONE once the last step has been
// taken.
// Optional feature macro: DECODER_IOT_EN. When defined, IOT decodes and takes
// two steps. When undefined, IOT is a one-step NOP and instIOT is held at 0.
//
// state   | meaning
// S_IDLE  | no instruction held since reset (VALID low)
// S_EXEC  | instruction fetched, execute steps in progress
// S_FIN   | DONE issued, decode held until the next fetch
module instruction_decoder (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [11:0] MEMDATA,
    input  logic        STB_FETCH,
    input  logic        STB_AUTOINC1,
    input  logic        STB_AUTOINC2,
    input  logic        STB_INDIRECT,
    input  logic        STB_1,
    input  logic        STB_2,
    input  logic        STB_3,
    input  logic        STB_4,
    input  logic        STB_5,
    input  logic        STB_6,
    output logic [1:0]  SEQTYPE,
    output logic        DONE,
    output logic [11:0] IR,
    output logic        instAND,
    output logic        instTAD,
    output logic        instISZ,
    output logic        instDCA,
    output logic        instJMS,
    output logic        instJMP,
    output logic        instIOT,
    output logic        instOPR,
    output logic        VALID,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] step;
    logic [2:0] step_next;
    logic [2:0] n_steps;
    logic [2:0] opcode;
    logic [7:0] stb_vec;
    logic       hit;
    logic       is_final;
    logic       fire_norm;
    logic       fire_ovr;
    logic [8:0] seq_src;
    logic       is_ind;
    logic       is_ppind;
    logic       unused_strobes;

    // Address-mode strobes only steer the external sequencer; they never touch step or DONE.
    assign unused_strobes = STB_AUTOINC1 | STB_AUTOINC2 | STB_INDIRECT;

    assign opcode = IR[11:9];

    // SEQTYPE looks through to MEMDATA during fetch so the sequencer can branch right away.
    always_comb begin
        seq_src  = STB_FETCH ? MEMDATA[11:3] : IR[11:3];
        is_ind   = (seq_src[8:6] < 3'd6) && seq_src[5];
        is_ppind = is_ind && !seq_src[4] && (seq_src[3:0] == 4'b0001);
        SEQTYPE  = {is_ppind, is_ind};
    end

    // Execute step count for the opcode that is held.
    always_comb begin
        n_steps = 3'd1;
        case (opcode)
            3'd2:    n_steps = 3'd3;
            3'd4:    n_steps = 3'd2;
`ifdef DECODER_IOT_EN
            3'd6:    n_steps = 3'd2;
`else
            3'd6:    n_steps = 3'd1;
`endif
            3'd7:    n_steps = 3'd3;
            default: n_steps = 3'd1;
        endcase
    end

    // Only the strobe for the next step in order counts. An out-of-order STB_6 is still an overrun.
    always_comb begin
        stb_vec   = {2'b00, STB_6, STB_5, STB_4, STB_3, STB_2, STB_1};
        hit       = stb_vec[step];
        step_next = step + 3'd1;
        is_final  = hit && (step_next == n_steps);
        fire_norm = (state == S_EXEC) && !STB_FETCH && is_final;
        fire_ovr  = (state == S_EXEC) && !STB_FETCH && STB_6 && !is_final;
    end

    // Sequencing FSM. A fetch always wins and restarts the instruction.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            IR    <= 12'd0;
            step  <= 3'd0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (STB_FETCH) begin
                IR    <= MEMDATA;
                step  <= 3'd0;
                state <= S_EXEC;
            end else if (state != S_IDLE) begin
                if (hit) begin
                    step <= step_next;
                end
                if (fire_norm || fire_ovr) begin
                    DONE  <= 1'b1;
                    state <= S_FIN;
                end
                if (fire_ovr) begin
                    ERR <= 1'b1;
                end
            end
        end
    end

    // One-hot decode, qualified by a held instruction.
    always_comb begin
        VALID   = (state != S_IDLE);
        instAND = VALID && (opcode == 3'd0);
        instTAD = VALID && (opcode == 3'd1);
        instISZ = VALID && (opcode == 3'd2);
        instDCA = VALID && (opcode == 3'd3);
        instJMS = VALID && (opcode == 3'd4);
        instJMP = VALID && (opcode == 3'd5);
`ifdef DECODER_IOT_EN
        instIOT = VALID && (opcode == 3'd6);
`else
        instIOT = 1'b0;
`endif
        instOPR = VALID && (opcode == 3'd7);
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder. Expected values are written out by
// hand from the opcode table and the step-count rules.
module tb_instruction_decoder;

    logic        clk;
    logic        rst_n;
    logic [11:0] MEMDATA;
    logic        STB_FETCH, STB_AUTOINC1, STB_AUTOINC2, STB_INDIRECT;
    logic        STB_1, STB_2, STB_3, STB_4, STB_5, STB_6;
    logic [1:0]  SEQTYPE;
    logic        DONE, VALID, ERR;
    logic [11:0] IR;
    logic        instAND, instTAD, instISZ, instDCA, instJMS, instJMP, instIOT, instOPR;
    logic [7:0]  inst;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    instruction_decoder dut (
        .CLK(clk), .RESET_N(rst_n), .MEMDATA(MEMDATA),
        .STB_FETCH(STB_FETCH), .STB_AUTOINC1(STB_AUTOINC1), .STB_AUTOINC2(STB_AUTOINC2),
        .STB_INDIRECT(STB_INDIRECT),
        .STB_1(STB_1), .STB_2(STB_2), .STB_3(STB_3), .STB_4(STB_4), .STB_5(STB_5), .STB_6(STB_6),
        .SEQTYPE(SEQTYPE), .DONE(DONE), .IR(IR),
        .instAND(instAND), .instTAD(instTAD), .instISZ(instISZ), .instDCA(instDCA),
        .instJMS(instJMS), .instJMP(instJMP), .instIOT(instIOT), .instOPR(instOPR),
        .VALID(VALID), .ERR(ERR)
    );

    assign inst = {instAND, instTAD, instISZ, instDCA, instJMS, instJMP, instIOT, instOPR};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count DONE pulses, sampled mid-cycle.
    always @(negedge clk) if (DONE === 1'b1) done_cnt <= done_cnt + 1;

    task automatic clear_strobes();
        STB_FETCH = 0; STB_AUTOINC1 = 0; STB_AUTOINC2 = 0; STB_INDIRECT = 0;
        STB_1 = 0; STB_2 = 0; STB_3 = 0; STB_4 = 0; STB_5 = 0; STB_6 = 0;
    endtask

    // One-cycle fetch pulse. Returns SEQTYPE as seen while STB_FETCH is high.
    task automatic do_fetch(input logic [11:0] w, output logic [1:0] seq);
        @(negedge clk);
        MEMDATA = w; STB_FETCH = 1;
        #1 seq = SEQTYPE;
        @(posedge clk); #1;
        STB_FETCH = 0; MEMDATA = 12'o7777;
    endtask

    // n = 1..6 execute strobes, 7/8 autoinc1/2, 9 indirect.
    task automatic strobe(input int n);
        @(negedge clk);
        case (n)
            1: STB_1 = 1; 2: STB_2 = 1; 3: STB_3 = 1;
            4: STB_4 = 1; 5: STB_5 = 1; 6: STB_6 = 1;
            7: STB_AUTOINC1 = 1; 8: STB_AUTOINC2 = 1;
            default: STB_INDIRECT = 1;
        endcase
        @(posedge clk); #1;
        clear_strobes();
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; MEMDATA = 12'o7777; clear_strobes();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (IR !== 12'd0) begin errors++; $display("FAIL reset_ir: got %o exp 0", IR); end
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", VALID); end
        checks++; if (inst !== 8'd0) begin errors++; $display("FAIL reset_inst: got %b exp 0", inst); end
        checks++; if (DONE !== 1'b0 || ERR !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b exp 00", DONE, ERR); end
        checks++; if (SEQTYPE !== 2'b00) begin errors++; $display("FAIL reset_seqtype: got %b exp 00", SEQTYPE); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_tad_direct();
        logic [1:0] seq;
        do_fetch(12'o1234, seq);
        checks++; if (seq !== 2'b00) begin errors++; $display("FAIL tad_seq: got %b exp 00", seq); end
        checks++; if (IR !== 12'o1234 || VALID !== 1'b1) begin errors++; $display("FAIL tad_ir: got %o/%b exp 1234/1", IR, VALID); end
        checks++; if (inst !== 8'b0100_0000) begin errors++; $display("FAIL tad_inst: got %b exp 01000000", inst); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL tad_early_done: got %b exp 0", DONE); end
        strobe(1);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL tad_done: got %b exp 1", DONE); end
        idle_cycle();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL tad_done_width: got %b exp 0", DONE); end
        checks++; if (inst !== 8'b0100_0000) begin errors++; $display("FAIL tad_hold: got %b exp 01000000", inst); end
    endtask

    task automatic test_and_autoinc();
        logic [1:0] seq;
        int c0;
        do_fetch(12'o0410, seq);
        checks++; if (seq !== 2'b11) begin errors++; $display("FAIL and_seq_fetch: got %b exp 11", seq); end
        checks++; if (SEQTYPE !== 2'b11) begin errors++; $display("FAIL and_seq_ir: got %b exp 11", SEQTYPE); end
        c0 = done_cnt;
        strobe(7); strobe(8); strobe(9);
        idle_cycle();
        checks++; if (done_cnt !== c0 || DONE !== 1'b0) begin errors++; $display("FAIL and_addr_strobes: got %0d dones exp 0", done_cnt - c0); end
        strobe(1);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL and_done: got %b exp 1", DONE); end
        checks++; if (inst !== 8'b1000_0000) begin errors++; $display("FAIL and_inst: got %b exp 10000000", inst); end
    endtask

    task automatic test_isz_three_steps();
        logic [1:0] seq;
        do_fetch(12'o2600, seq);
        checks++; if (seq !== 2'b01) begin errors++; $display("FAIL isz_seq: got %b exp 01", seq); end
        strobe(1);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL isz_step1: got %b exp 0", DONE); end
        strobe(2);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL isz_step2: got %b exp 0", DONE); end
        strobe(3);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL isz_step3: got %b exp 1", DONE); end
    endtask

    task automatic test_abort();
        logic [1:0] seq;
        int c0;
        do_fetch(12'o7200, seq);
        c0 = done_cnt;
        strobe(1); strobe(2);
        do_fetch(12'o5000, seq);
        idle_cycle();
        checks++; if (done_cnt !== c0) begin errors++; $display("FAIL abort_no_done: got %0d dones exp 0", done_cnt - c0); end
        checks++; if (IR !== 12'o5000) begin errors++; $display("FAIL abort_ir: got %o exp 5000", IR); end
        checks++; if (inst !== 8'b0000_0100) begin errors++; $display("FAIL abort_jmp: got %b exp 00000100", inst); end
        strobe(1);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL abort_done: got %b exp 1", DONE); end
    endtask

    task automatic test_fetch_collision();
        logic [1:0] seq;
        int c0;
        do_fetch(12'o5000, seq);
        c0 = done_cnt;
        @(negedge clk);
        MEMDATA = 12'o3000; STB_FETCH = 1; STB_1 = 1;
        @(posedge clk); #1;
        clear_strobes();
        checks++; if (DONE !== 1'b0 || IR !== 12'o3000) begin errors++; $display("FAIL collision: got done %b ir %o exp 0/3000", DONE, IR); end
        idle_cycle();
        checks++; if (done_cnt !== c0) begin errors++; $display("FAIL collision_cnt: got %0d dones exp 0", done_cnt - c0); end
        strobe(1);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL collision_done: got %b exp 1", DONE); end
    endtask

    task automatic test_overrun();
        logic [1:0] seq;
        int c0;
        do_fetch(12'o3000, seq);
        c0 = done_cnt;
        for (int i = 1; i <= 6; i++) strobe(i);
        idle_cycle();
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL dca_single_done: got %0d exp 1", done_cnt - c0); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL dca_err: got %b exp 0", ERR); end
        do_fetch(12'o3000, seq);
        strobe(3); strobe(5);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL ovr_ooo_ignored: got %b exp 0", DONE); end
        strobe(6);
        checks++; if (DONE !== 1'b1 || ERR !== 1'b1) begin errors++; $display("FAIL ovr_done_err: got %b%b exp 11", DONE, ERR); end
        do_fetch(12'o1234, seq);
        strobe(1);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", ERR); end
        @(negedge clk); rst_n = 0;
        #1;
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_reset: got %b exp 0", ERR); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_iot();
        logic [1:0] seq;
        do_fetch(12'o6410, seq);
        checks++; if (seq !== 2'b00) begin errors++; $display("FAIL iot_no_ind: got %b exp 00", seq); end
        do_fetch(12'o7410, seq);
        checks++; if (seq !== 2'b00) begin errors++; $display("FAIL opr_no_ind: got %b exp 00", seq); end
        do_fetch(12'o6031, seq);
        strobe(1);
`ifdef DECODER_IOT_EN
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL iot_step1: got %b exp 0", DONE); end
        strobe(2);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL iot_step2: got %b exp 1", DONE); end
        checks++; if (inst !== 8'b0000_0010) begin errors++; $display("FAIL iot_inst: got %b exp 00000010", inst); end
`else
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL iot_step1: got %b exp 1", DONE); end
        checks++; if (inst !== 8'b0000_0000) begin errors++; $display("FAIL iot_inst: got %b exp 00000000", inst); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq;
        int c0;
        do_fetch(12'o7200, seq);
        strobe(1);
        c0 = done_cnt;
        @(negedge clk); rst_n = 0;
        #1;
        checks++; if (VALID !== 1'b0 || IR !== 12'd0 || inst !== 8'd0) begin errors++; $display("FAIL midreset_clear: got %b %o %b exp 0 0 0", VALID, IR, inst); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        strobe(2); strobe(3);
        idle_cycle();
        checks++; if (done_cnt !== c0) begin errors++; $display("FAIL midreset_no_done: got %0d dones exp 0", done_cnt - c0); end
        do_fetch(12'o5000, seq);
        strobe(1);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL midreset_resume: got %b exp 1", DONE); end
    endtask

    initial begin
        test_reset();
        test_tad_direct();
        test_and_autoinc();
        test_isz_three_steps();
        test_abort();
        test_fetch_collision();
        test_overrun();
        test_iot();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
